// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants for the fetch path
package core_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_AR   = 2'd1,
        IFU_R    = 2'd2,
        IFU_OUT  = 2'd3
    } ifu_state_t;

    localparam logic [1:0]  RESP_OKAY = 2'b00;

    // Owned by the PC-update stage; kept here so every stage agrees on it.
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - PC request, instruction-memory read and decode handoff signals
interface ifu_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_in;
    logic              pc_valid;
    logic              pc_ready;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_fault;
    logic              inst_valid;
    logic              inst_ready;

    // master is the fetch unit's view; slave is the surrounding core/memory view
    modport master (
        input  pc_in, pc_valid, arready, rdata, rresp, rvalid, inst_ready,
        output pc_ready, araddr, arvalid, rready, inst, inst_pc, inst_fault, inst_valid
    );

    modport slave (
        output pc_in, pc_valid, arready, rdata, rresp, rvalid, inst_ready,
        input  pc_ready, araddr, arvalid, rready, inst, inst_pc, inst_fault, inst_valid
    );

endinterface

// File: rtl/ifu_fetch_timeout_cnt.sv
// rtl/ifu_fetch_timeout_cnt.sv - saturating read-response wait counter for the fetch unit
module ifu_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires in the last allowed wait cycle so the fault lands exactly LIMIT cycles in.
    assign expired = (cnt >= CNT_LAST);

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch unit; IFU_ALIGN_CHECK_EN enables misaligned-PC faulting
module ifu_fetch
    import core_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    ifu_fetch_if.master   bus
);

    ifu_state_t state;
    ifu_state_t state_nxt;

    logic [ADDR_W-1:0] araddr_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic [DATA_W-1:0] inst_q;
    logic              inst_fault_q;

    logic pc_hs;
    logic ar_hs;
    logic r_take;
    logic r_ok;
    logic expired;
    logic misaligned;

    logic pc_ready_c;
    logic arvalid_c;
    logic rready_c;
    logic inst_valid_c;

`ifdef IFU_ALIGN_CHECK_EN
    assign misaligned = (bus.pc_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign pc_hs  = (state == IFU_IDLE) && bus.pc_valid;
    assign ar_hs  = (state == IFU_AR)   && bus.arready;
    assign r_take = (state == IFU_R)    && bus.rvalid;
    assign r_ok   = (bus.rresp == RESP_OKAY);

    ifu_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (ar_hs),
        .en      ((state == IFU_R) && !bus.rvalid),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IFU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IFU_IDLE: if (bus.pc_valid)             state_nxt = misaligned ? IFU_OUT : IFU_AR;
            IFU_AR:   if (bus.arready)              state_nxt = IFU_R;
            IFU_R:    if (bus.rvalid || expired)    state_nxt = IFU_OUT;
            IFU_OUT:  if (bus.inst_ready)           state_nxt = IFU_IDLE;
            default:                                state_nxt = IFU_IDLE;
        endcase
    end

    always_comb begin
        pc_ready_c   = 1'b0;
        arvalid_c    = 1'b0;
        rready_c     = 1'b0;
        inst_valid_c = 1'b0;
        case (state)
            IFU_IDLE: pc_ready_c   = 1'b1;
            IFU_AR:   arvalid_c    = 1'b1;
            IFU_R:    rready_c     = 1'b1;
            IFU_OUT:  inst_valid_c = 1'b1;
            default:  pc_ready_c   = 1'b0;
        endcase
    end

    // Response data takes priority over a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            araddr_q     <= '0;
            inst_pc_q    <= '0;
            inst_q       <= '0;
            inst_fault_q <= 1'b0;
        end else begin
            if (pc_hs) begin
                inst_pc_q <= bus.pc_in;
                if (misaligned) begin
                    inst_q       <= '0;
                    inst_fault_q <= 1'b1;
                end else begin
                    araddr_q <= bus.pc_in;
                end
            end
            if (r_take) begin
                inst_q       <= r_ok ? bus.rdata : '0;
                inst_fault_q <= !r_ok;
            end else if ((state == IFU_R) && expired) begin
                inst_q       <= '0;
                inst_fault_q <= 1'b1;
            end
        end
    end

    assign bus.pc_ready   = pc_ready_c;
    assign bus.araddr     = araddr_q;
    assign bus.arvalid    = arvalid_c;
    assign bus.rready     = rready_c;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_fault = inst_fault_q;
    assign bus.inst_valid = inst_valid_c;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - scoreboard bench for ifu_fetch with directed fetch vectors
module tb_ifu_fetch;
    import core_pkg::*;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   hs_count;
    exp_t sb[$];
    exp_t e;

    ifu_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ifu_fetch #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every decode handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && bus.inst_valid && bus.inst_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_inst actual_pc=0x%0h required=none", bus.inst_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_inst",       bus.inst,       e.inst);
                chk("sb_inst_pc",    bus.inst_pc,    e.pc);
                chk("sb_inst_fault", bus.inst_fault, e.fault);
            end
        end
    end

    // r_dly < 0 means rvalid never comes (timeout path).
    task automatic run_fetch(input logic [31:0] pc, input int ar_dly, input int r_dly,
                             input logic [31:0] data, input logic [1:0] resp,
                             input int ir_dly, input bit noise);
        logic [31:0] ei;
        logic        ef;
        int          k;
        int          h0;
        if (r_dly >= 0 && resp == RESP_OKAY) begin
            ei = data;  ef = 1'b0;
        end else begin
            ei = 32'h0; ef = 1'b1;
        end
        sb.push_back('{inst: ei, pc: pc, fault: ef});
        chk("pc_ready_idle", bus.pc_ready, 1);
        bus.pc_in    = pc;
        bus.pc_valid = 1'b1;
        step;
        if (noise) begin
            bus.pc_in = pc ^ 32'h0000_0100;
        end else begin
            bus.pc_valid = 1'b0;
            bus.pc_in    = 32'h0;
        end
        chk("pc_ready_busy", bus.pc_ready, 0);
        for (int i = 0; i < ar_dly; i++) begin
            chk("arvalid_hold", bus.arvalid, 1);
            chk("araddr_hold",  bus.araddr,  pc);
            step;
        end
        chk("arvalid", bus.arvalid, 1);
        chk("araddr",  bus.araddr,  pc);
        bus.arready = 1'b1;
        step;
        bus.arready  = 1'b0;
        bus.pc_valid = 1'b0;
        bus.pc_in    = 32'h0;
        chk("rready", bus.rready, 1);
        if (r_dly >= 0) begin
            for (int i = 0; i < r_dly; i++) begin
                chk("r_wait_no_inst", bus.inst_valid, 0);
                step;
            end
            bus.rvalid = 1'b1;
            bus.rdata  = data;
            bus.rresp  = resp;
            step;
            bus.rvalid = 1'b0;
            bus.rdata  = 32'h0;
            bus.rresp  = 2'b00;
            chk("inst_valid_latency", bus.inst_valid, 1);
        end else begin
            k = 0;
            while (!bus.inst_valid && k < 20) begin
                step;
                k++;
            end
            chk("timeout_cycles", k, 8);
            chk("late_rready", bus.rready, 0);
            bus.rvalid = 1'b1;
            bus.rdata  = 32'h1111_2222;
        end
        for (int i = 0; i < ir_dly; i++) begin
            chk("inst_valid_hold", bus.inst_valid, 1);
            chk("inst_hold",       bus.inst,       ei);
            chk("inst_pc_hold",    bus.inst_pc,    pc);
            step;
        end
        h0 = hs_count;
        bus.inst_ready = 1'b1;
        step;
        bus.inst_ready = 1'b0;
        bus.rvalid     = 1'b0;
        bus.rdata      = 32'h0;
        chk("handshake_once", hs_count - h0, 1);
        chk("inst_valid_clr", bus.inst_valid, 0);
        chk("pc_ready_back",  bus.pc_ready,   1);
    endtask

    task automatic chk_reset_outputs;
        chk("rst_araddr",     bus.araddr,     0);
        chk("rst_arvalid",    bus.arvalid,    0);
        chk("rst_rready",     bus.rready,     0);
        chk("rst_inst",       bus.inst,       0);
        chk("rst_inst_pc",    bus.inst_pc,    0);
        chk("rst_inst_fault", bus.inst_fault, 0);
        chk("rst_inst_valid", bus.inst_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        checks   = 0;
        failures = 0;
        hs_count = 0;
        bus.pc_in      = 32'h0;
        bus.pc_valid   = 1'b0;
        bus.arready    = 1'b0;
        bus.rdata      = 32'h0;
        bus.rresp      = 2'b00;
        bus.rvalid     = 1'b0;
        bus.inst_ready = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #2 chk_reset_outputs();
        step;
        step;
        rst = 1'b1;
        step;
        chk("pc_ready_after_rst", bus.pc_ready, 1);

        // nominal, backpressure with stray pc_valid, expiry-cycle data, timeout, bus error
        run_fetch(RESET_PC,       0, 0, 32'h0000_0413, 2'b00, 0, 1'b0);
        run_fetch(32'h8000_0010,  4, 3, 32'h00a0_0093, 2'b00, 5, 1'b1);
        run_fetch(32'h8000_0050,  0, 7, 32'h0011_8193, 2'b00, 0, 1'b0);
        run_fetch(32'h8000_0030,  0, -1, 32'h0,        2'b00, 1, 1'b0);
        run_fetch(32'h8000_0020,  1, 1, 32'hDEAD_BEEF, 2'b10, 2, 1'b0);

        // async reset while waiting in R; stale fault/address must clear with no pulse
        bus.pc_in    = 32'h8000_0060;
        bus.pc_valid = 1'b1;
        step;
        bus.pc_valid = 1'b0;
        bus.arready  = 1'b1;
        step;
        bus.arready  = 1'b0;
        chk("mid_rready", bus.rready, 1);
        step;
        h0 = hs_count;
        #2 rst = 1'b0;
        #1 chk_reset_outputs();
        step;
        rst = 1'b1;
        step;
        chk("mid_pc_ready", bus.pc_ready, 1);
        chk("mid_no_pulse", hs_count - h0, 0);

        run_fetch(32'h8000_0040, 0, 0, 32'h1234_5678, 2'b00, 0, 1'b0);

`ifdef IFU_ALIGN_CHECK_EN
        sb.push_back('{inst: 32'h0, pc: 32'h8000_0002, fault: 1'b1});
        bus.pc_in    = 32'h8000_0002;
        bus.pc_valid = 1'b1;
        step;
        bus.pc_valid = 1'b0;
        bus.pc_in    = 32'h0;
        chk("align_arvalid",    bus.arvalid,    0);
        chk("align_inst_valid", bus.inst_valid, 1);
        bus.inst_ready = 1'b1;
        step;
        bus.inst_ready = 1'b0;
        chk("align_arvalid_after", bus.arvalid,  0);
        chk("align_pc_ready",      bus.pc_ready, 1);
`else
        run_fetch(32'h8000_0006, 0, 0, 32'h0000_0013, 2'b00, 0, 1'b0);
`endif

        step;
        chk("sb_empty",       sb.size(), 0);
        chk("total_handshakes", hs_count, 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
